// File: rtl/ahbl_sram_slave_if_if.sv
// AHB-Lite and SRAM-control bundle for ahbl_sram_slave_if.
// slave: DUT side (AHB in, SRAM req out); master: bus + memory side.
`timescale 1ns/1ps
interface ahbl_sram_slave_if_if #(
  parameter int unsigned MEM_AWIDTH = 19
);
  logic                  HSEL;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [31:0]           HWDATA;
  logic                  HREADYIN;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [31:0]           HRDATA;
  logic                  ahbsram_req;
  logic                  ahbsram_write;
  logic [2:0]            ahbsram_size;
  logic [MEM_AWIDTH-1:0] ahbsram_addr;
  logic [31:0]           ahbsram_wdata;
  logic                  sramahb_ack;
  logic [31:0]           sramahb_rdata;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE,
    input  HSIZE, HWDATA, HREADYIN,
    output HREADYOUT, HRESP, HRDATA,
    output ahbsram_req, ahbsram_write,
    output ahbsram_size, ahbsram_addr,
    output ahbsram_wdata,
    input  sramahb_ack, sramahb_rdata
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE,
    output HSIZE, HWDATA, HREADYIN,
    input  HREADYOUT, HRESP, HRDATA,
    input  ahbsram_req, ahbsram_write,
    input  ahbsram_size, ahbsram_addr,
    input  ahbsram_wdata,
    output sramahb_ack, sramahb_rdata
  );
endinterface

// File: rtl/ahbl_sram_slave_if.sv
// AHB-Lite slave front end for the on-chip SRAM: qualifies address phases,
// issues one-cycle SRAM requests, stretches HREADYOUT, makes ERROR responses.
// Ports: HCLK, aresetn (async, active-low), bus (ahbl_sram_slave_if_if.slave).
`timescale 1ns/1ps
module ahbl_sram_slave_if #(
  parameter int unsigned MEM_AWIDTH = 19,
  parameter int unsigned MEM_DEPTH  = 512
) (
  input  logic HCLK,
  input  logic aresetn,
  ahbl_sram_slave_if_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e state_q, state_d;

  logic                  hready_q, hready_d;
  logic                  hresp_q, hresp_d;
  logic                  req_q, req_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  logic [MEM_AWIDTH-1:0] addr_q, addr_d;

  logic                  valid;
  logic                  legal;
  logic                  bad_size;
  logic                  bad_align;
  logic                  bad_range;
  logic [MEM_AWIDTH-3:0] widx;
  logic                  unused_haddr;

  assign unused_haddr = ^bus.HADDR[31:MEM_AWIDTH];

  assign valid = bus.HSEL & bus.HREADYIN
               & bus.HTRANS[1] & hready_q;

  assign widx      = bus.HADDR[MEM_AWIDTH-1:2];
  assign bad_size  = bus.HSIZE > 3'b010;
  assign bad_align =
      ((bus.HSIZE == 3'b001) & bus.HADDR[0])
    | ((bus.HSIZE == 3'b010) & (|bus.HADDR[1:0]));
  assign bad_range = 32'(widx) >= MEM_DEPTH;
  assign legal     = ~(bad_size | bad_align | bad_range);

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (valid) begin
          if (legal) begin
            state_d = S_REQ;
            write_d = bus.HWRITE;
            size_d  = bus.HSIZE;
            addr_d  = bus.HADDR[MEM_AWIDTH-1:0];
          end else begin
            state_d = S_ERR1;
          end
        end
      end
      S_REQ:  state_d = bus.sramahb_ack ? S_IDLE : S_WAIT;
      S_WAIT: if (bus.sramahb_ack) state_d = S_IDLE;
      S_ERR1: state_d = S_ERR2;
      // An address phase shown during ERR2 is dropped.
      S_ERR2: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered, so derive them from the next state.
    hready_d = (state_d == S_IDLE) | (state_d == S_ERR2);
    hresp_d  = (state_d == S_ERR1) | (state_d == S_ERR2);
    req_d    = (state_d == S_REQ);
  end

  always_ff @(posedge HCLK or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      req_q    <= 1'b0;
      write_q  <= 1'b0;
      size_q   <= 3'b000;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      req_q    <= req_d;
      write_q  <= write_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
    end
  end

  assign bus.HREADYOUT     = hready_q;
  assign bus.HRESP         = hresp_q;
  assign bus.HRDATA        = bus.sramahb_rdata;
  assign bus.ahbsram_req   = req_q;
  assign bus.ahbsram_write = write_q;
  assign bus.ahbsram_size  = size_q;
  assign bus.ahbsram_addr  = addr_q;
  assign bus.ahbsram_wdata = bus.HWDATA;

endmodule

// File: tb/tb_ahbl_sram_slave_if.sv
// Testbench for ahbl_sram_slave_if: per-cycle timeline model
// filled from transfer-level rules, checked every cycle.
`timescale 1ns/1ps
module tb_ahbl_sram_slave_if;
  localparam int AW    = 19;
  localparam int DEPTH = 512;
  localparam int N     = 400;

  logic HCLK = 1'b0;
  logic aresetn = 1'b1;

  ahbl_sram_slave_if_if #(.MEM_AWIDTH(AW)) bus ();

  ahbl_sram_slave_if #(
    .MEM_AWIDTH(AW),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .HCLK   (HCLK),
    .aresetn(aresetn),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  bit          e_rdy  [N];
  bit          e_resp [N];
  bit          e_req  [N];
  logic [31:0] e_addr [N];
  bit          e_wr   [N];
  logic [2:0]  e_sz   [N];
  bit          wd_chk [N];
  logic [31:0] e_wd   [N];
  bit          rd_chk [N];
  logic [31:0] e_rd   [N];

  int          req_cyc [$];
  logic [31:0] req_adr [$];
  logic [31:0] req_wd  [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic bit legal_m(input logic [31:0] a,
                                 input logic [2:0] s);
    logic [31:0] word;
    word = 32'(a[AW-1:2]);
    if (s > 3'd2) return 1'b0;
    if (s == 3'd1 && a[0]) return 1'b0;
    if (s == 3'd2 && a[1:0] != 2'b00) return 1'b0;
    if (word >= DEPTH) return 1'b0;
    return 1'b1;
  endfunction

  // Address phase sampled at the end of cycle c; ack arrives
  // d cycles after the request cycle.
  function automatic void model_accept(
      input int c, input logic [31:0] a, input logic [2:0] s,
      input bit w, input logic [31:0] wd, input int d,
      input logic [31:0] rd);
    if (legal_m(a, s)) begin
      e_req[c+1] = 1'b1;
      for (int k = c + 1; k <= c + 1 + d; k++) e_rdy[k] = 1'b0;
      for (int k = c + 1; k < N; k++) begin
        e_addr[k] = {13'b0, a[AW-1:0]};
        e_wr[k]   = w;
        e_sz[k]   = s;
      end
      if (w) begin
        wd_chk[c+1] = 1'b1;
        e_wd[c+1]   = wd;
      end else begin
        rd_chk[c+2+d] = 1'b1;
        e_rd[c+2+d]   = rd;
      end
    end else begin
      e_rdy[c+1]  = 1'b0;
      e_resp[c+1] = 1'b1;
      e_resp[c+2] = 1'b1;
    end
  endfunction

  function automatic void model_reset(input int r);
    for (int k = r; k < N; k++) begin
      e_rdy[k]  = 1'b1;
      e_resp[k] = 1'b0;
      e_req[k]  = 1'b0;
      e_addr[k] = '0;
      e_wr[k]   = 1'b0;
      e_sz[k]   = '0;
      wd_chk[k] = 1'b0;
      rd_chk[k] = 1'b0;
    end
  endfunction

  always @(negedge HCLK) begin
    if (chk_en && cyc < N) begin
      chk("hready", 32'(bus.HREADYOUT), 32'(e_rdy[cyc]));
      chk("hresp", 32'(bus.HRESP), 32'(e_resp[cyc]));
      chk("req", 32'(bus.ahbsram_req), 32'(e_req[cyc]));
      chk("addr", 32'(bus.ahbsram_addr), e_addr[cyc]);
      chk("write", 32'(bus.ahbsram_write), 32'(e_wr[cyc]));
      chk("size", 32'(bus.ahbsram_size), 32'(e_sz[cyc]));
      if (wd_chk[cyc]) chk("wdata", bus.ahbsram_wdata, e_wd[cyc]);
      if (rd_chk[cyc]) chk("rdata", bus.HRDATA, e_rd[cyc]);
    end
  end

  always @(negedge HCLK) begin
    if (chk_en && bus.ahbsram_req) begin
      req_cyc.push_back(cyc);
      req_adr.push_back(32'(bus.ahbsram_addr));
      req_wd.push_back(bus.ahbsram_wdata);
    end
  end

  task automatic xfer(input logic [31:0] a, input logic [2:0] s,
                      input bit w, input logic [31:0] wd,
                      input int d, input logic [31:0] rd,
                      input logic [1:0] tr, input bit probe);
    int c;
    c = cyc;
    model_accept(c, a, s, w, wd, d, rd);
    bus.HSEL = 1'b1;
    bus.HREADYIN = 1'b1;
    bus.HTRANS = tr;
    bus.HADDR = a;
    bus.HSIZE = s;
    bus.HWRITE = w;
    @(posedge HCLK); #1;
    bus.HTRANS = 2'b00;
    bus.HWDATA = wd;
    if (legal_m(a, s)) begin
      for (int k = 0; k <= d; k++) begin
        if (k == d) begin
          bus.sramahb_ack = 1'b1;
          bus.sramahb_rdata = rd;
        end
        @(posedge HCLK); #1;
        bus.sramahb_ack = 1'b0;
      end
    end else begin
      @(posedge HCLK); #1;
      if (probe) begin
        bus.HTRANS = 2'b10;
        bus.HADDR = 32'h20;
        bus.HSIZE = 3'b010;
        bus.HWRITE = 1'b1;
      end
      @(posedge HCLK); #1;
      bus.HTRANS = 2'b00;
    end
  endtask

  task automatic idle_vec(input bit sel, input logic [1:0] tr,
                          input bit rin, input bit ack);
    bus.HSEL = sel;
    bus.HTRANS = tr;
    bus.HREADYIN = rin;
    bus.HADDR = 32'h0000_0018;
    bus.HSIZE = 3'b010;
    bus.sramahb_ack = ack;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HREADYIN = 1'b1;
    bus.sramahb_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int c;
    model_reset(0);
    bus.HSEL = 1'b0;
    bus.HADDR = '0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HSIZE = 3'b000;
    bus.HWDATA = '0;
    bus.HREADYIN = 1'b1;
    bus.sramahb_ack = 1'b0;
    bus.sramahb_rdata = '0;

    #1 aresetn = 1'b0;
    #1;
    chk("rst_hready", 32'(bus.HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(bus.HRESP), 32'd0);
    chk("rst_req", 32'(bus.ahbsram_req), 32'd0);
    chk("rst_addr", 32'(bus.ahbsram_addr), 32'd0);
    chk("rst_write", 32'(bus.ahbsram_write), 32'd0);
    chk("rst_size", 32'(bus.ahbsram_size), 32'd0);

    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    aresetn = 1'b1;
    chk_en = 1'b1;
    @(posedge HCLK); #1;

    xfer(32'h10, 3'b010, 1'b1, 32'hDEADBEEF, 1, 32'h0, 2'b10, 1'b0);
    chk("wr_nreq", 32'(req_cyc.size()), 32'd1);
    chk("wr_addr", req_adr[0], 32'h10);
    chk("wr_wdata", req_wd[0], 32'hDEADBEEF);

    xfer(32'h10, 3'b010, 1'b0, 32'h0, 1, 32'hDEADBEEF, 2'b10, 1'b0);
    chk("rd_hrdata", bus.HRDATA, 32'hDEADBEEF);
    chk("rd_write", 32'(bus.ahbsram_write), 32'd0);
    chk("rd_hready", 32'(bus.HREADYOUT), 32'd1);

    n0 = req_cyc.size();
    xfer(32'h0, 3'b010, 1'b0, 32'h0, 1, 32'hA0, 2'b10, 1'b0);
    xfer(32'h4, 3'b010, 1'b0, 32'h0, 1, 32'hA4, 2'b11, 1'b0);
    xfer(32'h8, 3'b010, 1'b0, 32'h0, 1, 32'hA8, 2'b11, 1'b0);
    xfer(32'hC, 3'b010, 1'b0, 32'h0, 1, 32'hAC, 2'b11, 1'b0);
    chk("b2b_nreq", 32'(req_cyc.size() - n0), 32'd4);
    if (req_cyc.size() - n0 == 4) begin
      for (int i = 1; i < 4; i++)
        chk("b2b_gap", 32'(req_cyc[n0+i] - req_cyc[n0+i-1]), 32'd3);
      for (int i = 0; i < 4; i++)
        chk("b2b_addr", req_adr[n0+i], 32'(4 * i));
    end

    xfer(32'h6, 3'b001, 1'b1, 32'h0000BEEF, 0, 32'h0, 2'b10, 1'b0);
    xfer(32'h5, 3'b000, 1'b0, 32'h0, 2, 32'h55, 2'b10, 1'b0);

    n0 = req_cyc.size();
    xfer(32'h2, 3'b010, 1'b0, 32'h0, 1, 32'h0, 2'b10, 1'b0);
    xfer(32'h800, 3'b010, 1'b0, 32'h0, 1, 32'h0, 2'b10, 1'b0);
    xfer(32'h3, 3'b001, 1'b1, 32'h0, 1, 32'h0, 2'b10, 1'b0);
    xfer(32'h0, 3'b011, 1'b0, 32'h0, 1, 32'h0, 2'b10, 1'b1);
    xfer(32'h7FC, 3'b010, 1'b0, 32'h0, 1, 32'h77, 2'b10, 1'b0);
    chk("err_nreq", 32'(req_cyc.size() - n0), 32'd1);

    n0 = req_cyc.size();
    idle_vec(1'b1, 2'b00, 1'b1, 1'b0);
    idle_vec(1'b1, 2'b01, 1'b1, 1'b0);
    idle_vec(1'b0, 2'b10, 1'b1, 1'b0);
    idle_vec(1'b1, 2'b10, 1'b0, 1'b0);
    idle_vec(1'b0, 2'b00, 1'b1, 1'b1);
    @(posedge HCLK); #1;
    chk("idle_nreq", 32'(req_cyc.size() - n0), 32'd0);

    c = cyc;
    model_accept(c, 32'h8, 3'b010, 1'b0, 32'h0, 10, 32'h0);
    bus.HSEL = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR = 32'h8;
    bus.HSIZE = 3'b010;
    bus.HWRITE = 1'b0;
    @(posedge HCLK); #1;
    bus.HTRANS = 2'b00;
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    chk("wait_hready", 32'(bus.HREADYOUT), 32'd0);
    #1 aresetn = 1'b0;
    model_reset(cyc);
    #1;
    chk("ar_hready", 32'(bus.HREADYOUT), 32'd1);
    chk("ar_req", 32'(bus.ahbsram_req), 32'd0);
    chk("ar_addr", 32'(bus.ahbsram_addr), 32'd0);
    @(posedge HCLK); #1;
    aresetn = 1'b1;
    @(posedge HCLK); #1;

    xfer(32'h4, 3'b010, 1'b0, 32'h0, 1, 32'h12345678, 2'b10, 1'b0);
    chk("post_rdata", bus.HRDATA, 32'h12345678);
    chk("post_addr", 32'(bus.ahbsram_addr), 32'h4);

    repeat (3) @(posedge HCLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahbl_sram_slave_if.md
Name: ahbl_sram_slave_if

Overview:
AHB-Lite slave front end for the on-chip SRAM subsystem.
- Decodes and qualifies AHB-Lite address phases, checks alignment, size and range, and latches transfer control.
- Issues a single-cycle request to the downstream SRAM control interface (ahbsram_* / sramahb_* handshake).
- Stretches the AHB data phase with HREADYOUT until the downstream acknowledges, and generates two-cycle ERROR responses for illegal transfers.

Parameters:
- MEM_AWIDTH, 19, width of the byte address forwarded downstream (ahbsram_addr).
- MEM_DEPTH, 512, number of 32-bit words implemented; word index >= MEM_DEPTH is out of range.

Ports:
- HCLK  input  1  clock; all logic rising-edge.
- aresetn  input  1  reset, asynchronous, active-low.
- HSEL  input  1  slave select.
- HADDR  input  32  AHB address; only [MEM_AWIDTH-1:0] used.
- HTRANS  input  2  transfer type; NONSEQ=2'b10, SEQ=2'b11 valid.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  transfer size; 000 byte, 001 half, 010 word.
- HWDATA  input  32  write data, valid in data phase.
- HREADYIN  input  1  bus-level HREADY.
- HREADYOUT  output  1  slave ready.
- HRESP  output  1  0 = OKAY, 1 = ERROR.
- HRDATA  output  32  read data.
- ahbsram_req  output  1  single-cycle request to SRAM control.
- ahbsram_write  output  1  latched HWRITE.
- ahbsram_size  output  3  latched HSIZE.
- ahbsram_addr  output  MEM_AWIDTH  latched HADDR[MEM_AWIDTH-1:0].
- ahbsram_wdata  output  32  equals HWDATA (combinational pass-through).
- sramahb_ack  input  1  downstream completion, single-cycle pulse.
- sramahb_rdata  input  32  downstream read data register.

Behaviour:
- Reset (async, aresetn=0): state IDLE; HREADYOUT=1; HRESP=0; ahbsram_req=0; ahbsram_write=0; ahbsram_size=0; ahbsram_addr=0. Reset mid-transfer aborts immediately and drops req the same instant; no ack is awaited.
- Valid transfer: HSEL & HREADYIN & HTRANS[1] sampled at a rising edge while HREADYOUT=1.
- HTRANS IDLE/BUSY, or HSEL=0, gives a zero-wait OKAY; no request is issued.
- Illegal transfer, checked on the address phase:
  - HSIZE > 3'b010;
  - HSIZE=001 with HADDR[0]=1;
  - HSIZE=010 with HADDR[1:0]!=0;
  - HADDR[MEM_AWIDTH-1:2] >= MEM_DEPTH.
- Control registers (write, size, addr) load only on a legal valid transfer. They hold otherwise.
- FSM states are IDLE, REQ, WAIT, ERR1 and ERR2. All outputs are registered except ahbsram_wdata and HRDATA.
  - IDLE: HREADYOUT=1, HRESP=0. Legal valid transfer -> REQ. Illegal transfer -> ERR1. Otherwise stay in IDLE.
  - REQ: ahbsram_req=1 for exactly one cycle; HREADYOUT=0. Write data is taken from HWDATA this cycle; the master holds HWDATA while HREADYOUT=0. If sramahb_ack=1 -> IDLE, else -> WAIT.
  - WAIT: HREADYOUT=0; req=0. On sramahb_ack=1 -> IDLE. No timeout.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1 -> IDLE. A new address phase presented in ERR2 is ignored; the master must reissue it.
- HREADYOUT rises in the cycle after ack, because it is registered. Pipelined back-to-back: an address phase sampled on that same edge is accepted, so the next REQ follows without an idle cycle.
- HRDATA = sramahb_rdata. It is valid in the cycle where HREADYOUT=1 after a read ack, because downstream updates rdata on the ack cycle.
- Latency: ack one cycle after req gives 2 wait states per transfer (addr phase t, REQ t+1, ack t+2, HREADYOUT=1 at t+3).
- A spurious ack in IDLE/ERR states is ignored.

Test Plan:
- Word write: HADDR=0x10, HSIZE=010, HWDATA=0xDEADBEEF, ack 1 cycle after req -> req pulses once with addr=0x10, wdata=0xDEADBEEF; HREADYOUT low 2 cycles; HRESP=0.
- Word read after that write: HADDR=0x10, sramahb_rdata=0xDEADBEEF -> HRDATA=0xDEADBEEF when HREADYOUT returns to 1; ahbsram_write=0.
- Back-to-back pipelined: 4 NONSEQ/SEQ reads at 0x0, 0x4, 0x8, 0xC -> 4 req pulses, each 3 cycles apart; no IDLE gap; addresses in order.
- Illegal cases:
  - HSIZE=010, HADDR=0x2 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); no req.
  - Same for HADDR=MEM_DEPTH*4=0x800.
  - Same for HSIZE=011.
- IDLE/BUSY HTRANS and HSEL=0 with HREADYIN=1 -> HREADYOUT stays 1, HRESP=0, no req; HREADYIN=0 with a valid HTRANS -> ignored.
- Reset asserted in WAIT with ack pending -> HREADYOUT=1, req=0, addr=0 immediately; after release, a subsequent read at 0x4 completes normally.
